// File: rtl/paper_float_dot_sequencer.sv
// Feeds operand pairs from a small FIFO into a paper-float MAC PE, clearing it
// before each dot product and returning the drained accumulator over valid/ready.
module paper_float_dot_sequencer #(
    parameter int EXP   = 5,
    parameter int FRAC  = 10,
    parameter int DEPTH = 4,
    parameter int LEN_W = 16,
    localparam int WIDTH = 1 + EXP + FRAC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [LEN_W-1:0] cmdLen,
    input  logic             opValid,
    output logic             opReady,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] peA,
    output logic [WIDTH-1:0] peB,
    output logic             peReset,
    input  logic [WIDTH-1:0] peC,
    output logic             resValid,
    input  logic             resReady,
    output logic [WIDTH-1:0] resData
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, empty;
    logic [LEN_W-1:0] remaining, remaining_n;
    logic [1:0]       drain_cnt, drain_n;
    logic [WIDTH-1:0] pe_a_n, pe_b_n, res_data_n;
    logic             pe_reset_n, res_valid_n;

    assign opReady = (count != (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = opValid && opReady;

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr] <= opA;
            mem_b[wr_ptr] <= opB;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        drain_n     = drain_cnt;
        pop         = 1'b0;
        pe_a_n      = '0;
        pe_b_n      = '0;
        pe_reset_n  = 1'b0;
        res_data_n  = resData;
        res_valid_n = resValid;
        cmdReady    = 1'b0;
        case (state)
            IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    remaining_n = cmdLen;
                    state_n     = CLEAR;
                end
            end
            CLEAR: begin
                pe_reset_n = 1'b1;
                state_n    = STREAM;
            end
            STREAM: begin
                if (remaining == '0) begin
                    state_n = DRAIN;
                    drain_n = 2'd2;
                end else if (!empty) begin
                    pop         = 1'b1;
                    pe_a_n      = mem_a[rd_ptr];
                    pe_b_n      = mem_b[rd_ptr];
                    remaining_n = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_n = DRAIN;
                        drain_n = 2'd2;
                    end
                end
            end
            DRAIN: begin
                // Two cycles of PE latency elapse before the last product lands in peC.
                if (drain_cnt == 2'd0) begin
                    res_data_n  = peC;
                    res_valid_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    drain_n = drain_cnt - 2'd1;
                end
            end
            DONE: begin
                if (resValid && resReady) begin
                    res_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            drain_cnt <= '0;
            peA       <= '0;
            peB       <= '0;
            peReset   <= 1'b1;
            resData   <= '0;
            resValid  <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            drain_cnt <= drain_n;
            peA       <= pe_a_n;
            peB       <= pe_b_n;
            peReset   <= pe_reset_n;
            resData   <= res_data_n;
            resValid  <= res_valid_n;
        end
    end
endmodule

// File: tb/tb_paper_float_dot_sequencer.sv
// Bench for the dot-product sequencer: behavioural half-precision MAC PE,
// directed vector table, multi-cycle corner sequences and randomized commands.
module tb_paper_float_dot_sequencer;
    logic        clock = 1'b0, reset = 1'b1;
    logic        cmdValid = 1'b0, cmdReady;
    logic [15:0] cmdLen = '0;
    logic        opValid = 1'b0, opReady;
    logic [15:0] opA = '0, opB = '0;
    logic [15:0] peA, peB, peC, resData;
    logic        peReset, resValid, resReady = 1'b0;

    int tests = 0, fails = 0, cyc = 0;
    logic [31:0] ref_q[$];
    bit mon_en = 0, mon_pe_bad = 0, mon_op_bad = 0;

    paper_float_dot_sequencer dut (
        .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdLen(cmdLen),
        .opValid(opValid), .opReady(opReady), .opA(opA), .opB(opB), .peA(peA), .peB(peB),
        .peReset(peReset), .peC(peC), .resValid(resValid), .resReady(resReady), .resData(resData)
    );

    always #5 clock = ~clock;

    function automatic real h2r(input logic [15:0] h);
        real r;
        int e;
        if (h[14:10] == 5'd0) return 0.0;
        r = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        real m;
        int e, f;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        f = $rtoi((m - 1.0) * 1024.0 + 0.5);
        return {s, 5'(e), 10'(f)};
    endfunction

    // PE model: operand registers, then accumulate; synchronous clear.
    logic [15:0] pa_r, pb_r;
    real acc;
    always @(posedge clock) begin
        if (peReset) begin
            pa_r <= '0; pb_r <= '0; acc <= 0.0;
        end else begin
            pa_r <= peA; pb_r <= peB; acc <= acc + h2r(pa_r) * h2r(pb_r);
        end
    end
    always_comb peC = r2h(acc);

    always @(negedge clock) if (mon_en) begin
        if (peA != 16'h0 || peB != 16'h0) mon_pe_bad = 1;
        if (!opReady) mon_op_bad = 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        @(negedge clock);
        opValid = 1'b1; opA = a; opB = b;
        while (!opReady && t < 500) begin @(negedge clock); t++; end
        if (!opReady) begin
            tests++; fails++;
            $display("FAIL push_timeout: got opReady=0 expected 1");
            opValid = 1'b0;
        end else begin
            ref_q.push_back({a, b});
            @(posedge clock); #1 opValid = 1'b0;
        end
    endtask

    task automatic push_at(input int c, input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        do begin @(negedge clock); #1; t++; end while (cyc != c && t < 200);
        check("push_at_ready", {31'd0, opReady}, 32'd1);
        opValid = 1'b1; opA = a; opB = b;
        @(posedge clock); #1 opValid = 1'b0;
    endtask

    // Issues one command; lat is the cycle (accept = 0) in which resValid rises.
    task automatic run_cmd(input int len, input bit rr, output int lat, output logic [15:0] data,
                           output logic pr2);
        int t;
        bit got;
        got = 0; lat = -1; data = '0; pr2 = 0; cyc = 0; t = 0;
        @(negedge clock);
        while (!cmdReady && t < 300) begin @(negedge clock); t++; end
        cmdValid = 1'b1; cmdLen = 16'(len);
        @(posedge clock); #1 cmdValid = 1'b0;
        @(negedge clock); cyc = 1;
        while (cyc < 400) begin
            if (cyc == 2) pr2 = peReset;
            if (resValid && !got) begin got = 1; lat = cyc; data = resData; end
            resReady = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (got && resReady) begin @(posedge clock); #1 resReady = 1'b0; break; end
            @(negedge clock); cyc++;
        end
        if (!got) lat = -1;
    endtask

    typedef struct {
        int              n;
        logic [3:0][15:0] a;   // element [0] is pushed first
        logic [3:0][15:0] b;
        logic [15:0]     exp_data;
        int              exp_lat;
    } vec_t;

    vec_t vec [5];
    int lat, t;
    logic [15:0] data;
    logic pr2;
    logic [15:0] ops [5];

    initial begin
        vec[0] = '{4, {16'h3800, 16'h4200, 16'h4000, 16'h3C00}, {4{16'h4000}}, 16'h4A80, 9};
        vec[1] = '{0, {4{16'h0000}}, {4{16'h0000}}, 16'h0000, 6};
        vec[2] = '{1, {16'h0, 16'h0, 16'h0, 16'h4000}, {16'h0, 16'h0, 16'h0, 16'h4200}, 16'h4600, 6};
        vec[3] = '{2, {16'h0, 16'h0, 16'h3C00, 16'h3C00}, {16'h0, 16'h0, 16'h3C00, 16'h3C00}, 16'h4000, 7};
        vec[4] = '{3, {16'h0, 16'h3E00, 16'h4000, 16'h4200}, {16'h0, 16'h4000, 16'h3800, 16'h4000}, 16'h4900, 8};
        ops = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200, 16'h3E00};

        #12;
        check("rst_peReset", {31'd0, peReset}, 32'd1);
        check("rst_resValid", {31'd0, resValid}, 32'd0);
        check("rst_opReady", {31'd0, opReady}, 32'd1);
        check("rst_cmdReady", {31'd0, cmdReady}, 32'd1);
        check("rst_peA", {16'd0, peA}, 32'd0);
        check("rst_resData", {16'd0, resData}, 32'd0);
        @(negedge clock); reset = 1'b0;
        #1 check("rel_peReset_held", {31'd0, peReset}, 32'd1);
        @(negedge clock);
        check("rel_peReset_fall", {31'd0, peReset}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vec[i].n; k++) push_pair(vec[i].a[k], vec[i].b[k]);
            mon_en = (vec[i].n == 0); mon_pe_bad = 0; mon_op_bad = 0;
            run_cmd(vec[i].n, 0, lat, data, pr2);
            mon_en = 0;
            check($sformatf("vec%0d_data", i), {16'd0, data}, {16'd0, vec[i].exp_data});
            check($sformatf("vec%0d_lat", i), lat, vec[i].exp_lat);
            check($sformatf("vec%0d_peReset_c2", i), {31'd0, pr2}, 32'd1);
            if (vec[i].n == 0) begin
                check("zero_pe_quiet", {31'd0, mon_pe_bad}, 32'd0);
                check("zero_opReady", {31'd0, mon_op_bad}, 32'd0);
            end
        end

        // Operand starvation: second pair arrives late, bubbles fill the gap.
        fork
            run_cmd(2, 0, lat, data, pr2);
            begin push_at(1, 16'h3C00, 16'h3C00); push_at(6, 16'h3C00, 16'h3C00); end
        join
        check("starve_data", {16'd0, data}, 32'h4000);
        check("starve_lat", lat, 11);

        // Full FIFO with surplus operands carried into the next command.
        repeat (4) push_pair(16'h3C00, 16'h3C00);
        @(negedge clock);
        check("full_opReady", {31'd0, opReady}, 32'd0);
        fork
            run_cmd(2, 0, lat, data, pr2);
            begin push_pair(16'h3C00, 16'h3C00); push_pair(16'h3C00, 16'h3C00); end
        join
        check("surplus_data", {16'd0, data}, 32'h4000);
        @(negedge clock);
        check("surplus_full", {31'd0, opReady}, 32'd0);
        run_cmd(4, 0, lat, data, pr2);
        check("surplus2_data", {16'd0, data}, 32'h4400);
        @(negedge clock);
        check("surplus2_empty", {31'd0, opReady}, 32'd1);

        // Result backpressure, then a command offered with the handshake.
        push_pair(16'h4000, 16'h4200); push_pair(16'h3C00, 16'h3C00);
        resReady = 1'b0;
        @(negedge clock);
        cmdValid = 1'b1; cmdLen = 16'd1;
        @(posedge clock); #1 cmdValid = 1'b0;
        t = 0;
        while (!resValid && t < 50) begin @(negedge clock); t++; end
        check("bp_valid", {31'd0, resValid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {16'd0, resData}, 32'h4600);
            check("bp_cmdReady", {31'd0, cmdReady}, 32'd0);
            @(negedge clock);
        end
        resReady = 1'b1; cmdValid = 1'b1; cmdLen = 16'd1;
        @(posedge clock); #1 resReady = 1'b0;
        @(negedge clock);
        check("b2b_cmdReady", {31'd0, cmdReady}, 32'd1);
        check("b2b_resValid", {31'd0, resValid}, 32'd0);
        @(posedge clock); #1 cmdValid = 1'b0;
        t = 0;
        while (!resValid && t < 50) begin @(negedge clock); t++; end
        check("b2b_data", {16'd0, resData}, 32'h3C00);
        resReady = 1'b1;
        @(posedge clock); #1 resReady = 1'b0;

        // Reset in the middle of streaming discards FIFO contents and the PE sum.
        repeat (4) push_pair(16'h3C00, 16'h3C00);
        @(negedge clock);
        cmdValid = 1'b1; cmdLen = 16'd4;
        @(posedge clock); #1 cmdValid = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_peReset", {31'd0, peReset}, 32'd1);
        check("mid_rst_resValid", {31'd0, resValid}, 32'd0);
        check("mid_rst_opReady", {31'd0, opReady}, 32'd1);
        check("mid_rst_cmdReady", {31'd0, cmdReady}, 32'd1);
        @(negedge clock); reset = 1'b0;
        push_pair(16'h4000, 16'h4200);
        run_cmd(1, 0, lat, data, pr2);
        check("post_rst_data", {16'd0, data}, 32'h4600);
        check("post_rst_lat", lat, 6);

        // Randomized commands against a queue-based dot-product reference.
        ref_q.delete();
        for (int k = 0; k < 12; k++) begin
            int n;
            real sum;
            n = $urandom_range(0, 6);
            fork
                run_cmd(n, 1, lat, data, pr2);
                for (int j = 0; j < n; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    push_pair(ops[$urandom_range(0, 4)], ops[$urandom_range(0, 4)]);
                end
            join
            sum = 0.0;
            for (int j = 0; j < n; j++) begin
                logic [31:0] p;
                p = ref_q.pop_front();
                sum = sum + h2r(p[31:16]) * h2r(p[15:0]);
            end
            check($sformatf("rand%0d_n%0d_data", k, n), {16'd0, data}, {16'd0, r2h(sum)});
            check($sformatf("rand%0d_seen", k), {31'd0, lat > 0}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
